// File: rtl/stream_arb_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_pkg
//   Shared types for the two-input arbitrated stream selector.
//   - arb_state_t : arbiter FSM state (IDLE, or locked to one source for a packet)
//   - src_t       : identifies a source channel; its encoding is also the
//                   value driven on y_sel (0 = A, 1 = B)
// -----------------------------------------------------------------------------
package stream_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_t;

endpackage : stream_arb_pkg

// File: rtl/stream_arb_mux_2x1_rr_arb_2.sv
// -----------------------------------------------------------------------------
// rr_arb_2
//   Combinational 2-way grant logic for stream_arb_mux_2x1. Holds no state:
//   the caller owns the FSM state and the round-robin pointer.
//
//   Ports:
//     req_a, req_b  in   request (valid) from channel A / B
//     rr_ptr        in   source that won the most recent packet
//     state         in   current arbiter state
//     grant_valid   out  a source is granted this cycle
//     grant         out  granted source (meaningful only with grant_valid)
// -----------------------------------------------------------------------------
module rr_arb_2
   import stream_arb_pkg::*;
(
   input  logic       req_a,
   input  logic       req_b,
   input  src_t       rr_ptr,
   input  arb_state_t state,
   output logic       grant_valid,
   output src_t       grant
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      grant_valid = 1'b0;
      grant       = SRC_A;
      unique case (state)
         IDLE: begin
            if (req_a && req_b) begin
               // Tie: the side that did not win last time goes first.
               grant_valid = 1'b1;
               grant       = (rr_ptr == SRC_A) ? SRC_B : SRC_A;
            end else if (req_a) begin
               grant_valid = 1'b1;
               grant       = SRC_A;
            end else if (req_b) begin
               grant_valid = 1'b1;
               grant       = SRC_B;
            end
         end
         // Mid-packet the other source is ignored; a gap simply yields no grant.
         LOCK_A: begin
            grant_valid = req_a;
            grant       = SRC_A;
         end
         LOCK_B: begin
            grant_valid = req_b;
            grant       = SRC_B;
         end
         default: begin
            grant_valid = 1'b0;
            grant       = SRC_A;
         end
      endcase
   end

endmodule : rr_arb_2

// File: rtl/stream_arb_mux_2x1.sv
// -----------------------------------------------------------------------------
// stream_arb_mux_2x1
//   Merges two valid/ready packet streams (A, B) onto one registered output
//   stream. Round-robin between packets; the select is locked from the first
//   beat of a packet until its last beat has transferred.
//
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     a_valid/a_ready/a_data/a_last   channel A input stream
//     b_valid/b_ready/b_data/b_last   channel B input stream
//     y_valid/y_ready/y_data/y_last   registered output stream
//     y_sel                           source of current output beat (0=A, 1=B)
// -----------------------------------------------------------------------------
module stream_arb_mux_2x1
   import stream_arb_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              a_valid,
   output logic              a_ready,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_last,

   input  logic              b_valid,
   output logic              b_ready,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_last,

   output logic              y_valid,
   input  logic              y_ready,
   output logic [DATA_W-1:0] y_data,
   output logic              y_last,
   output logic              y_sel
);

   arb_state_t        state_q,   state_d;
   src_t              rr_ptr_q,  rr_ptr_d;
   logic              y_valid_q, y_valid_d;
   logic [DATA_W-1:0] y_data_q,  y_data_d;
   logic              y_last_q,  y_last_d;
   src_t              y_sel_q,   y_sel_d;

   logic              grant_valid;
   src_t              grant;
   logic              load;
   logic              xfer;
   logic              sel_last;

   rr_arb_2 u_rr_arb (
      .req_a       (a_valid),
      .req_b       (b_valid),
      .rr_ptr      (rr_ptr_q),
      .state       (state_q),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // The output register can take a new beat when it is empty or draining.
   assign load = !y_valid_q || y_ready;

   // During reset the register reads empty, so load alone would raise a ready;
   // gating with rst_n keeps both readies low while reset is asserted.
   assign a_ready = rst_n && load && grant_valid && (grant == SRC_A);
   assign b_ready = rst_n && load && grant_valid && (grant == SRC_B);

   assign xfer     = (a_valid && a_ready) || (b_valid && b_ready);
   assign sel_last = (grant == SRC_A) ? a_last : b_last;

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      y_valid_d = y_valid_q;
      y_data_d  = y_data_q;
      y_last_d  = y_last_q;
      y_sel_d   = y_sel_q;

      if (load) begin
         y_valid_d = xfer;
         if (xfer) begin
            y_data_d = (grant == SRC_A) ? a_data : b_data;
            y_last_d = sel_last;
            y_sel_d  = grant;
         end
      end

      if (xfer) begin
         if (sel_last) begin
            // Packet complete (including single-beat packets from IDLE):
            // remember the winner so the other side wins the next tie.
            state_d  = IDLE;
            rr_ptr_d = grant;
         end else if (state_q == IDLE) begin
            state_d = (grant == SRC_A) ? LOCK_A : LOCK_B;
         end
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge value of its _d signal.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= SRC_B;
         y_valid_q <= 1'b0;
         y_data_q  <= '0;
         y_last_q  <= 1'b0;
         y_sel_q   <= SRC_A;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         y_valid_q <= y_valid_d;
         y_data_q  <= y_data_d;
         y_last_q  <= y_last_d;
         y_sel_q   <= y_sel_d;
      end
   end

   assign y_valid = y_valid_q;
   assign y_data  = y_data_q;
   assign y_last  = y_last_q;
   assign y_sel   = y_sel_q;

endmodule : stream_arb_mux_2x1

// File: tb/tb_stream_arb_mux_2x1.sv
// -----------------------------------------------------------------------------
// tb_stream_arb_mux_2x1
//   Directed bench for stream_arb_mux_2x1. Inputs change 1 time unit after the
//   rising edge; outputs are sampled at that same point, well away from it.
//   Output comparisons use the packed tuple {y_valid, y_sel, y_last, y_data}.
// -----------------------------------------------------------------------------
module tb_stream_arb_mux_2x1;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              a_valid, a_ready, a_last;
   logic [DATA_W-1:0] a_data;
   logic              b_valid, b_ready, b_last;
   logic [DATA_W-1:0] b_data;
   logic              y_valid, y_ready, y_last, y_sel;
   logic [DATA_W-1:0] y_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_arb_mux_2x1 #(.DATA_W(DATA_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a_data  (a_data),
      .a_last  (a_last),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .b_data  (b_data),
      .b_last  (b_last),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .y_data  (y_data),
      .y_last  (y_last),
      .y_sel   (y_sel)
   );

   function automatic logic [10:0] y_tuple();
      return {y_valid, y_sel, y_last, y_data};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      a_valid = 1'b1; a_data = 8'h00; a_last = 1'b1;
      b_valid = 1'b1; b_data = 8'h00; b_last = 1'b1;
      y_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (y_tuple() !== 11'h000) begin
         errors++;
         $display("FAIL reset_y: got %h expected %h", y_tuple(), 11'h000);
      end
      checks++;
      if ({a_ready, b_ready} !== 2'b00) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 00", {a_ready, b_ready});
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst_n   = 1'b1;
      tick();
   endtask

   // Both sides continuously valid with single beats: strict alternation, A first.
   task automatic test_alternate();
      logic [10:0] exp;
      a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1;
      b_valid = 1'b1; b_data = 8'h22; b_last = 1'b1;
      y_ready = 1'b1;
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b10) begin
         errors++;
         $display("FAIL alt_first_tie: got %b expected 10", {a_ready, b_ready});
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         exp = (i % 2 == 0) ? {3'b101, 8'h11} : {3'b111, 8'h22};
         checks++;
         if (y_tuple() !== exp) begin
            errors++;
            $display("FAIL alt_beat%0d: got %h expected %h", i, y_tuple(), exp);
         end
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      checks++;
      if (y_valid !== 1'b0) begin
         errors++;
         $display("FAIL alt_drain: got y_valid=%b expected 0", y_valid);
      end
   endtask

   // A 3-beat packet holds the lock against a waiting B; then round-robin.
   task automatic test_lock();
      logic [7:0] a_seq [3];
      a_seq[0] = 8'hA0; a_seq[1] = 8'hA1; a_seq[2] = 8'hA2;
      b_valid = 1'b1; b_data = 8'hB0; b_last = 1'b1;
      a_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_data = a_seq[i];
         a_last = (i == 2);
         #1;
         checks++;
         if ({a_ready, b_ready} !== 2'b10) begin
            errors++;
            $display("FAIL lock_ready%0d: got %b expected 10", i, {a_ready, b_ready});
         end
         tick();
         checks++;
         if (y_tuple() !== {2'b10, (i == 2), a_seq[i]}) begin
            errors++;
            $display("FAIL lock_beat%0d: got %h expected %h", i, y_tuple(),
                     {2'b10, (i == 2), a_seq[i]});
         end
      end
      // A offers another single beat; B must now win the tie.
      a_data = 8'hA3; a_last = 1'b1;
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b01) begin
         errors++;
         $display("FAIL lock_release_ready: got %b expected 01", {a_ready, b_ready});
      end
      tick();
      checks++;
      if (y_tuple() !== {3'b111, 8'hB0}) begin
         errors++;
         $display("FAIL lock_b_beat: got %h expected %h", y_tuple(), {3'b111, 8'hB0});
      end
      b_valid = 1'b0;
      tick();
      checks++;
      if (y_tuple() !== {3'b101, 8'hA3}) begin
         errors++;
         $display("FAIL lock_a3_beat: got %h expected %h", y_tuple(), {3'b101, 8'hA3});
      end
      a_valid = 1'b0;
      tick();
   endtask

   // Output stalled for 4 cycles: everything holds, then no bubble on release.
   task automatic test_backpressure();
      a_valid = 1'b1; a_data = 8'h5A; a_last = 1'b1;
      b_valid = 1'b0;
      y_ready = 1'b1;
      tick();
      y_ready = 1'b0;
      a_data  = 8'h5B;
      b_valid = 1'b1; b_data = 8'hC3; b_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({y_tuple(), a_ready, b_ready} !== {3'b101, 8'h5A, 2'b00}) begin
            errors++;
            $display("FAIL bp_hold%0d: got %h expected %h", i,
                     {y_tuple(), a_ready, b_ready}, {3'b101, 8'h5A, 2'b00});
         end
         tick();
      end
      y_ready = 1'b1;
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_release_ready: got %b expected 01", {a_ready, b_ready});
      end
      tick();
      checks++;
      if (y_tuple() !== {3'b111, 8'hC3}) begin
         errors++;
         $display("FAIL bp_next_beat: got %h expected %h", y_tuple(), {3'b111, 8'hC3});
      end
      b_valid = 1'b0;
      tick();
      checks++;
      if (y_tuple() !== {3'b101, 8'h5B}) begin
         errors++;
         $display("FAIL bp_a_beat: got %h expected %h", y_tuple(), {3'b101, 8'h5B});
      end
      a_valid = 1'b0;
      tick();
   endtask

   // B packet with a 2-cycle gap while A waits: A must not slip in.
   task automatic test_gap();
      a_valid = 1'b1; a_data = 8'hAA; a_last = 1'b1;
      b_valid = 1'b1; b_data = 8'hB0; b_last = 1'b0;
      tick();
      checks++;
      if (y_tuple() !== {3'b110, 8'hB0}) begin
         errors++;
         $display("FAIL gap_first: got %h expected %h", y_tuple(), {3'b110, 8'hB0});
      end
      b_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if ({a_ready, b_ready} !== 2'b00) begin
            errors++;
            $display("FAIL gap_ready%0d: got %b expected 00", i, {a_ready, b_ready});
         end
         tick();
         checks++;
         if (y_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_bubble%0d: got y_valid=%b expected 0", i, y_valid);
         end
      end
      b_valid = 1'b1; b_data = 8'hB1; b_last = 1'b1;
      tick();
      checks++;
      if (y_tuple() !== {3'b111, 8'hB1}) begin
         errors++;
         $display("FAIL gap_second: got %h expected %h", y_tuple(), {3'b111, 8'hB1});
      end
      b_valid = 1'b0;
      tick();
      checks++;
      if (y_tuple() !== {3'b101, 8'hAA}) begin
         errors++;
         $display("FAIL gap_a_after: got %h expected %h", y_tuple(), {3'b101, 8'hAA});
      end
      a_valid = 1'b0;
      tick();
   endtask

   // Asynchronous reset in the middle of a locked A packet.
   task automatic test_reset_mid();
      a_valid = 1'b1; a_data = 8'hE0; a_last = 1'b0;
      b_valid = 1'b0;
      y_ready = 1'b1;
      tick();
      y_ready = 1'b0;
      a_data  = 8'hE1;
      #1;
      checks++;
      if (y_tuple() !== {3'b100, 8'hE0}) begin
         errors++;
         $display("FAIL rmid_pre: got %h expected %h", y_tuple(), {3'b100, 8'hE0});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({y_tuple(), a_ready} !== 12'h000) begin
         errors++;
         $display("FAIL rmid_async: got %h expected %h", {y_tuple(), a_ready}, 12'h000);
      end
      #1;
      rst_n = 1'b1;
      a_data = 8'h31; a_last = 1'b1;
      b_valid = 1'b1; b_data = 8'h32; b_last = 1'b1;
      y_ready = 1'b1;
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b10) begin
         errors++;
         $display("FAIL rmid_tie: got %b expected 10", {a_ready, b_ready});
      end
      tick();
      checks++;
      if (y_tuple() !== {3'b101, 8'h31}) begin
         errors++;
         $display("FAIL rmid_a: got %h expected %h", y_tuple(), {3'b101, 8'h31});
      end
      tick();
      checks++;
      if (y_tuple() !== {3'b111, 8'h32}) begin
         errors++;
         $display("FAIL rmid_b: got %h expected %h", y_tuple(), {3'b111, 8'h32});
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
   endtask

   // Only B requests: full rate even though B won last.
   task automatic test_one_sided();
      a_valid = 1'b0;
      b_valid = 1'b1; b_last = 1'b1; b_data = 8'h01;
      y_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++;
         if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL one_ready%0d: got %b expected 1", i, b_ready);
         end
         tick();
         checks++;
         if (y_tuple() !== {3'b111, 8'(i)}) begin
            errors++;
            $display("FAIL one_beat%0d: got %h expected %h", i, y_tuple(), {3'b111, 8'(i)});
         end
         b_data = 8'(i + 1);
      end
      b_valid = 1'b0;
      tick();
      checks++;
      if (y_valid !== 1'b0) begin
         errors++;
         $display("FAIL one_drain: got y_valid=%b expected 0", y_valid);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_alternate();
      test_lock();
      test_backpressure();
      test_gap();
      test_reset_mid();
      test_one_sided();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_stream_arb_mux_2x1
